// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// FSM states, datapath select codes and instruction field encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] SRCA_REG    = 2'd0;
  localparam logic [1:0] SRCA_PC     = 2'd1;
  localparam logic [1:0] SRCA_ALUOUT = 2'd2;

  localparam logic [1:0] SRCB_WD   = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALURES = 2'd2;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction and ALU flags in,
// every select and enable out.
interface mc_controller_if;

  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;

  modport master (
    input  Instr,
    input  ALUFlags,
    output PCWrite,
    output MemWrite,
    output RegWrite,
    output IRWrite,
    output AdrSrc,
    output RegSrc,
    output ALUSrcA,
    output ALUSrcB,
    output ResultSrc,
    output ImmSrc,
    output ALUControl
  );

  modport slave (
    output Instr,
    output ALUFlags,
    input  PCWrite,
    input  MemWrite,
    input  RegWrite,
    input  IRWrite,
    input  AdrSrc,
    input  RegSrc,
    input  ALUSrcA,
    input  ALUSrcB,
    input  ResultSrc,
    input  ImmSrc,
    input  ALUControl
  );

endinterface

// File: rtl/mc_cond_logic.sv
// Conditional execution: stored NZ/CV flags, condition table,
// registered CondExD and gating of the architectural write enables.
module mc_cond_logic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       pcs_i,
  input  logic       next_pc_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       cond_ex_q;
  logic       cond_ex;
  logic       n, z, c, v;

  assign n = nz_q[1];
  assign z = nz_q[0];
  assign c = cv_q[1];
  assign v = cv_q[0];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond_i)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // CondExD is sampled from the pre-update flags on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nz_q      <= 2'b00;
      cv_q      <= 2'b00;
      cond_ex_q <= 1'b0;
    end else begin
      if (flag_w_i[1] & cond_ex)
        nz_q <= alu_flags_i[3:2];
      if (flag_w_i[0] & cond_ex)
        cv_q <= alu_flags_i[1:0];
      cond_ex_q <= cond_ex;
    end
  end

  assign pc_write_o  = next_pc_i | (pcs_i & cond_ex_q);
  assign reg_write_o = reg_w_i & cond_ex_q;
  assign mem_write_o = mem_w_i & cond_ex_q;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main FSM, instruction/ALU decode,
// and the conditional-execution sub-block.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mc_controller_if.master bus
);

  state_e state_q, state_d;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cond;

  logic       next_pc;
  logic       branch;
  logic       reg_w;
  logic       mem_w;
  logic       ir_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;

  logic [1:0] alu_ctl;
  logic [1:0] flag_w;
  logic       pcs;
  logic       unused_instr_bits;

  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd    = bus.Instr[15:12];
  assign cond  = bus.Instr[31:28];

  assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_write   = 1'b0;
    adr_src    = ADR_PC;
    alu_src_a  = SRCA_REG;
    alu_src_b  = SRCB_WD;
    result_src = RES_ALUOUT;
    alu_op     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        unique case (1'b1)
          (op == OP_MEM):             state_d = S_MEMADR;
          (op == OP_DP) &  funct[5]:  state_d = S_EXECI;
          (op == OP_DP) & ~funct[5]:  state_d = S_EXECR;
          (op == OP_BR):              state_d = S_BRANCH;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = ADR_ALUOUT;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = ADR_ALUOUT;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_op    = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Unrecognised commands fall back to add and never touch the flags
  always_comb begin
    alu_ctl = ALU_ADD;
    flag_w  = 2'b00;
    if (alu_op) begin
      unique case (funct[4:1])
        CMD_ADD: begin
          alu_ctl = ALU_ADD;
          flag_w  = {2{funct[0]}};
        end
        CMD_SUB: begin
          alu_ctl = ALU_SUB;
          flag_w  = {2{funct[0]}};
        end
        CMD_AND: begin
          alu_ctl = ALU_AND;
          flag_w  = {funct[0], 1'b0};
        end
        CMD_ORR: begin
          alu_ctl = ALU_ORR;
          flag_w  = {funct[0], 1'b0};
        end
        default: begin
          alu_ctl = ALU_ADD;
          flag_w  = 2'b00;
        end
      endcase
    end
  end

  assign pcs = ((rd == REG_PC) & reg_w) | branch;

  mc_cond_logic u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (cond),
    .alu_flags_i (bus.ALUFlags),
    .flag_w_i    (flag_w),
    .pcs_i       (pcs),
    .next_pc_i   (next_pc),
    .reg_w_i     (reg_w),
    .mem_w_i     (mem_w),
    .pc_write_o  (bus.PCWrite),
    .reg_write_o (bus.RegWrite),
    .mem_write_o (bus.MemWrite)
  );

  assign bus.IRWrite    = ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction phase model
// pushes expected output vectors; a negedge monitor compares them.
module tb_mc_controller;

  typedef struct packed {
    logic       pcw;
    logic       memw;
    logic       regw;
    logic       irw;
    logic       adr;
    logic [1:0] regsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] imm;
    logic [1:0] aluc;
  } ovec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int    checks = 0;
  int    errors = 0;
  ovec_t exp_q[$];
  string tag_q[$];
  logic [3:0] nzcv_m = 4'h0;
  bit    rst_pending = 1'b0;

  function automatic ovec_t actual();
    ovec_t a;
    a.pcw    = bus.PCWrite;
    a.memw   = bus.MemWrite;
    a.regw   = bus.RegWrite;
    a.irw    = bus.IRWrite;
    a.adr    = bus.AdrSrc;
    a.regsrc = bus.RegSrc;
    a.srca   = bus.ALUSrcA;
    a.srcb   = bus.ALUSrcB;
    a.res    = bus.ResultSrc;
    a.imm    = bus.ImmSrc;
    a.aluc   = bus.ALUControl;
    return a;
  endfunction

  function automatic logic cond_ok(logic [3:0] c, logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(logic [3:0] cmd);
    case (cmd)
      4'd4:  return 2'b00;
      4'd2:  return 2'b01;
      4'd0:  return 2'b10;
      4'd12: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic ovec_t expect_phase(string ph, logic [31:0] ins,
                                         logic cx);
    ovec_t e;
    logic [1:0] op;
    logic wr_pc;
    op = ins[27:26];
    wr_pc = (ins[15:12] == 4'd15) && cx;
    e = '0;
    e.imm = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    if (ph == "FETCH") begin
      e.irw = 1; e.pcw = 1; e.srca = 1; e.srcb = 2; e.res = 2;
    end else if (ph == "DECODE") begin
      e.srca = 1; e.srcb = 2; e.res = 2;
    end else if (ph == "MEMADR") begin
      e.srcb = 1;
    end else if (ph == "MEMREAD") begin
      e.adr = 1;
    end else if (ph == "MEMWB") begin
      e.res = 1; e.regw = cx; e.pcw = wr_pc;
    end else if (ph == "MEMWRITE") begin
      e.adr = 1; e.memw = cx;
    end else if (ph == "EXEC") begin
      e.srcb = {1'b0, ins[25]};
      e.aluc = alu_of(ins[24:21]);
    end else if (ph == "ALUWB") begin
      e.regw = cx; e.pcw = wr_pc;
    end else if (ph == "BRANCH") begin
      e.srcb = 1; e.res = 2; e.pcw = cx;
    end
    return e;
  endfunction

  task automatic compare_vec(string tag, ovec_t act, ovec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", tag, act, exp);
    end
  endtask

  task automatic update_flags(logic [31:0] ins, logic [3:0] f, logic cx);
    logic [3:0] cmd;
    bit known, arith;
    cmd = ins[24:21];
    arith = (cmd == 4'd4) || (cmd == 4'd2);
    known = arith || (cmd == 4'd0) || (cmd == 4'd12);
    if (ins[20] && cx && known) begin
      nzcv_m[3:2] = f[3:2];
      if (arith) nzcv_m[1:0] = f[1:0];
    end
  endtask

  task automatic run_instr(logic [31:0] ins, bit use_exec,
                           logic [3:0] exec_flags, int abort_at,
                           string name);
    string phases[$];
    logic cx;
    ovec_t e;
    phases = '{"FETCH", "DECODE"};
    case (ins[27:26])
      2'b00: begin phases.push_back("EXEC"); phases.push_back("ALUWB"); end
      2'b01: begin
        phases.push_back("MEMADR");
        if (ins[20]) begin
          phases.push_back("MEMREAD"); phases.push_back("MEMWB");
        end else phases.push_back("MEMWRITE");
      end
      2'b10: phases.push_back("BRANCH");
      default: ;
    endcase
    cx = cond_ok(ins[31:28], nzcv_m);
    foreach (phases[i]) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        bus.Instr = ins;
        if (rst_pending) begin
          reset = 1'b1;
          rst_pending = 1'b0;
        end
      end
      if (phases[i] == "EXEC" && use_exec) bus.ALUFlags = exec_flags;
      else bus.ALUFlags = 4'($urandom);
      if (i == abort_at) begin
        #1;
        compare_vec({name, ":pre_rst"}, actual(),
                    expect_phase(phases[i], ins, cx));
        reset = 1'b0;
        #1;
        e = expect_phase("FETCH", ins, 1'b0);
        compare_vec({name, ":rst_async"}, actual(), e);
        nzcv_m = 4'h0;
        exp_q.push_back(e);
        tag_q.push_back({name, ":rst_cycle"});
        rst_pending = 1'b1;
        return;
      end
      exp_q.push_back(expect_phase(phases[i], ins, cx));
      tag_q.push_back({name, ":", phases[i]});
      if (phases[i] == "EXEC") update_flags(ins, bus.ALUFlags, cx);
    end
  endtask

  task automatic probe_flags(string tag);
    run_instr(32'h0A000002, 0, 4'h0, -1, {tag, "_BEQ"});
    run_instr(32'h4A000002, 0, 4'h0, -1, {tag, "_BMI"});
    run_instr(32'h2A000002, 0, 4'h0, -1, {tag, "_BCS"});
    run_instr(32'h6A000002, 0, 4'h0, -1, {tag, "_BVS"});
  endtask

  initial begin : monitor
    string t;
    ovec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        compare_vec(t, actual(), e);
      end
    end
  end

  initial begin : stim
    bus.Instr = 32'hE0812003;
    bus.ALUFlags = 4'h0;
    #2;
    compare_vec("reset_state", actual(),
                expect_phase("FETCH", 32'hE0812003, 1'b0));
    rst_pending = 1'b1;

    run_instr(32'hE0812003, 0, 4'h0, -1, "ADD");
    run_instr(32'hE0512003, 1, 4'b0100, -1, "SUBS");
    run_instr(32'h0A000002, 0, 4'h0, -1, "BEQ_taken");
    run_instr(32'h1A000002, 0, 4'h0, -1, "BNE_not");
    run_instr(32'hE5912004, 0, 4'h0, -1, "LDR");
    run_instr(32'hE5812004, 0, 4'h0, -1, "STR");
    run_instr(32'hEC000000, 0, 4'h0, -1, "NOP");
    run_instr(32'hE0512003, 1, 4'b0000, -1, "SUBS_clr");
    run_instr(32'h00912003, 1, 4'b1111, -1, "ADDEQS");
    probe_flags("after_ADDEQS");
    run_instr(32'hE0912003, 1, 4'b1111, -1, "ADDS_set");
    run_instr(32'hE0800000 | 32'h0000F000, 0, 4'h0, -1, "ADD_PC");
    run_instr(32'hE5812004, 0, 4'h0, 3, "STR_rst");
    probe_flags("after_rst");

    for (int k = 0; k < 300; k++)
      run_instr($urandom, 0, 4'h0, -1, $sformatf("rnd%0d", k));

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Control unit for the multicycle ARM processor, sitting directly upstream of the multicycle datapath. It contains the main-FSM sequencer, the instruction decoder and the conditional-execution logic. It consumes `Instr` and `ALUFlags` from the datapath and drives every datapath select and enable, plus `MemWrite` to the unified memory.

## Interface
Parameters:
- none; all widths are fixed by the 32-bit ARM subset.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; state and flags clear immediately while low.
- `Instr`  in  32  current instruction register contents from the datapath.
- `ALUFlags`  in  4  {N,Z,C,V} from the datapath ALU, same cycle.
- `PCWrite`  out  1  PC register enable.
- `MemWrite`  out  1  memory write enable.
- `RegWrite`  out  1  register file write enable.
- `IRWrite`  out  1  instruction register enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `RegSrc`  out  2  [0]: RA1 = R15; [1]: RA2 = Rd.
- `ALUSrcA`  out  2  0 = A, 1 = PC, 2 = ALUOut.
- `ALUSrcB`  out  2  0 = WriteData, 1 = ExtImm, 2 = constant 4.
- `ResultSrc`  out  2  0 = ALUOut, 1 = Data, 2 = ALUResult.
- `ImmSrc`  out  2  equals Op = `Instr[27:26]`.
- `ALUControl`  out  2  00 add, 01 sub, 10 and, 11 orr.

## Operation
**Field decode.** Op = `Instr[27:26]`, Funct = `Instr[25:20]`, Rd = `Instr[15:12]`, Cond = `Instr[31:28]`.
- `RegSrc[0]` = (Op==10).
- `RegSrc[1]` = (Op==01).
- Both are combinational from `Instr` in every state.

**FSM states and Moore outputs.** Unlisted outputs are 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=2, add, ResultSrc=2, NextPC=1. Next state: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=2, add, ResultSrc=2. Next state depends on Op:
  - Op=01 → MEMADR.
  - Op=00 with Funct[5]=1 → EXECUTEI.
  - Op=00 with Funct[5]=0 → EXECUTER.
  - Op=10 → BRANCH.
  - Op=11 → FETCH (unsupported instruction treated as NOP).
- MEMADR: ALUSrcA=0, ALUSrcB=1, add. Next state: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=0. Next state: MEMWB.
- MEMWB: ResultSrc=1, RegW=1. Next state: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=0, MemW=1. Next state: FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=0, ALUOp=1. Next state: ALUWB.
- EXECUTEI: as EXECUTER, but ALUSrcB=1. Next state: ALUWB.
- ALUWB: ResultSrc=0, RegW=1. Next state: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=1, add, ResultSrc=2, Branch=1. Next state: FETCH.

**ALU decode (ALUOp=1).** Funct[4:1] selects the operation:
- 0100 → add; 0010 → sub; 0000 → and; 1100 → orr.
- Any other value → add, and no flag write.
- FlagW[1] (N,Z) = Funct[0].
- FlagW[0] (C,V) = Funct[0] & (add|sub).

**Conditional logic.**
- CondEx evaluates from Cond and the stored flags, using the standard ARM table EQ..AL (e.g. HI = C&~Z, GE = N==V, GT = ~Z&(N==V)). Cond=1111 → CondEx=0.
- Stored flags: NZ register loads `ALUFlags[3:2]` when FlagW[1]&CondEx; CV register loads `ALUFlags[1:0]` when FlagW[0]&CondEx.
- CondExD register samples CondEx every cycle.
- PCS = (Rd==15 & RegW) | Branch.
- Gated outputs:
  - PCWrite = NextPC | (PCS & CondExD).
  - RegWrite = RegW & CondExD.
  - MemWrite = MemW & CondExD.

## Timing
- **Instruction latency:** branch 3 cycles; STR 4; data-processing 4; LDR 5; Op=11 2.
- **Flag timing:** flags update on the clock edge that ends EXECUTER/EXECUTEI. CondExD latched on that same edge uses the pre-update flags, so an `S` instruction's condition is judged on the old flags.
- **Condition for BRANCH:** taken from CondExD latched at the end of DECODE.
- **Reset (`reset` low):**
  - State = FETCH; NZ = CV = 00; CondExD = 0.
  - Outputs therefore show FETCH values: IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0. The datapath registers are held in reset regardless.
  - Deassertion mid-instruction resumes at FETCH; no partial write ever occurs after reset.
- **Output glitches:** outputs are glitch-free Moore functions of state plus registered CondExD. The only combinational inputs are `Instr`, which is stable after FETCH, and CondEx, which is used only for flag enables.

## Structure
- **Package `mc_ctrl_pkg`** holds:
  - the state enum (10 states);
  - ALUControl codes;
  - the ALUSrcA/ALUSrcB/ResultSrc/AdrSrc select constants;
  - the Op and Cond encodings.
- **Sub-module `mc_cond_logic`** holds the flag registers, the CondEx table, the CondExD register and the output gating.
- The FSM and decoder stay in `mc_controller`.

## Test plan
- **Register ADD:** `Instr`=0xE0812003 (ADD R2,R1,R3). Required response:
  - state sequence FETCH→DECODE→EXECUTER→ALUWB→FETCH;
  - ALUControl=00 in EXECUTER;
  - RegWrite=1 only in ALUWB;
  - no flag change.
- **SUBS then BEQ/BNE:** 0xE0512003 with ALUFlags=0100 in EXECUTER → Z stored. Then:
  - BEQ 0x0A000002 → PCWrite=1 in BRANCH.
  - BNE 0x1A000002 → PCWrite=0 in BRANCH.
- **Load:** LDR 0xE5912004. Required response:
  - MEMADR ALUSrcB=1;
  - MEMREAD AdrSrc=1;
  - MEMWB ResultSrc=1 with RegWrite=1;
  - 5 cycles total.
- **Store:** STR 0xE5812004 → MemWrite=1 and AdrSrc=1 only in MEMWRITE; 4 cycles total.
- **Failed condition:** Z=0, then ADDEQS 0x00912003 with ALUFlags=1111. Required response:
  - RegWrite=0 in ALUWB;
  - stored NZCV unchanged (0000).
- **Reset mid-operation:** drive `reset` low during MEMWRITE. Required response:
  - MemWrite drops to 0 immediately, without waiting for a clock edge;
  - state = FETCH, flags = 0;
  - after release, the next edge moves to DECODE.
